irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
Interrupt controller for the peripheral subsystem. Collects the per-peripheral interrupt lines (UART rx_ready, Ethernet 1/2 rx_ready, spare lines) and latches rising edges into a pending register. Exposes enable, pending and highest-priority-ID registers on a 32-bit AXI-Lite slave port, and drives one registered interrupt line to the core. It sits as an additional slave window behind the AXI-Lite interconnect.

Parameters:
N_SRC, 8, number of interrupt sources (1..31)
SYNC_STAGES, 2, synchronizer flops per source (≥1); sources may come from the clk_25_mhz domain

Ports:
clk_50_mhz  input  1  system clock; all logic on rising edge
rst  input  1  reset: synchronous, active-high
irq_src  input  N_SRC  raw interrupt lines, bit i = source i
awaddr  input  4  write address (byte, word aligned)
awvalid  input  1  write address valid
awready  output  1  write address ready
wdata  input  32  write data
wvalid  input  1  write data valid
wready  output  1  write data ready
bresp  output  2  write response
bvalid  output  1  write response valid
bready  input  1  write response ready
araddr  input  4  read address
arvalid  input  1  read address valid
arready  output  1  read address ready
rdata  output  32  read data
rresp  output  2  read response
rvalid  output  1  read data valid
rready  input  1  read data ready
irq_out  output  1  interrupt to core, registered

Behaviour:
- Reset (rst=1 at a clock edge): pending, enable and sync/edge flops = 0; all ready/valid outputs 0; bresp, rresp and rdata = 0; irq_out = 0. Reset mid-transaction drops the transaction; no response is issued.
- Edge capture: irq_src[i] passes through SYNC_STAGES flops, then a previous-value flop. A synchronized 0->1 transition sets pending[i]. A level held high does not re-set pending after it is cleared. Latency: rising edge sampled at cycle t -> pending[i]=1 at t+SYNC_STAGES+1.
- Register map (awaddr/araddr[3:2]):
  - 0x0: PENDING. Read returns pending. Write-1-to-clear.
  - 0x4: ENABLE. Read/write, N_SRC bits; upper bits read 0.
  - 0x8: ID, read-only. bit31 = any (pending&enable); bits[4:0] = lowest index i with pending[i]&enable[i]; 0 when none. Writes ignored, bresp OKAY.
  - 0xC: SWTRIG (see Optional Feature).
- Set/clear collision: an edge on bit i and a W1C of bit i in the same cycle leave pending[i]=1 (set wins).
- irq_out = registered OR(pending & enable). It is 1 the cycle after a pending/enable bit becomes set, and 0 the cycle after the last one clears.
- Write channel:
  - Accepts only when awvalid&wvalid are both 1 and bvalid=0.
  - awready and wready pulse high together for exactly one cycle; the register updates on that edge.
  - bvalid rises the next cycle, bresp=OKAY(00), and holds until bready. No acceptance while bvalid=1.
  - An address alone, or data alone, is not accepted.
- Read channel:
  - arready pulses one cycle when arvalid=1 and rvalid=0.
  - rdata is registered from the register state at acceptance. rvalid rises the next cycle and holds, with rdata stable, until rready.
- Simultaneous read and write in the same cycle: both are accepted. The read returns the pre-write value.
- Address bits [1:0] are ignored. wstrb is not supported; full-word writes only.

Optional Feature:
Macro IRQ_CTRL_SWTRIG_EN.
- Defined: 0xC SWTRIG. Writing 1 to bit i sets pending[i] (write-1-to-set) on the write edge. It reads 0. W1C to PENDING in the same cycle is impossible, since there is a single write port.
- Undefined: 0xC reads 0, writes are ignored, and bresp=SLVERR(10) for both read and write to 0xC. No SWTRIG logic is synthesized.

Test Plan:
- Reset: hold rst=1 for 3 cycles with irq_src=all 1 -> after release, all outputs 0 and PENDING reads 0x0; the held-high lines do not set pending.
- Edge + latency (SYNC_STAGES=2): write ENABLE=0x05; pulse irq_src[2] one cycle at t -> pending[2]=1 at t+3, irq_out=1 at t+4; ID reads 0x80000002.
- Priority / masking: edges on sources 1, 3, 6 with ENABLE=0x48 -> ID=0x80000003, irq_out=1. Write PENDING=0x08 -> ID=0x80000006. Write ENABLE=0 -> irq_out=0, ID=0x00000000, PENDING still reads 0x42.
- Set-wins collision: W1C of bit 0 on the same edge that a synchronized rise on source 0 arrives -> PENDING bit0 reads 1.
- Handshake: awvalid asserted 3 cycles before wvalid -> no awready until wvalid. Hold bready=0 for 5 cycles -> bvalid stays 1, and a second write is not accepted until bready. Read with rready=0 for 4 cycles -> rdata stable.
- SWTRIG: with macro, write 0xC=0x10 -> PENDING reads 0x10 and bresp=00. Without macro, the same write leaves PENDING=0 and bresp=10.

Source files
------------

// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronizes and edge-captures N_SRC lines into PENDING and exposes
// PENDING/ENABLE/ID over AXI-Lite. Define IRQ_CTRL_SWTRIG_EN to enable the 0xC SWTRIG register.
module irq_ctrl #(
    parameter int N_SRC       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_50_mhz,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_src,
    input  logic [3:0]       awaddr,
    input  logic             awvalid,
    output logic             awready,
    input  logic [31:0]      wdata,
    input  logic             wvalid,
    output logic             wready,
    output logic [1:0]       bresp,
    output logic             bvalid,
    input  logic             bready,
    input  logic [3:0]       araddr,
    input  logic             arvalid,
    output logic             arready,
    output logic [31:0]      rdata,
    output logic [1:0]       rresp,
    output logic             rvalid,
    input  logic             rready,
    output logic             irq_out
);

    localparam int                ARM_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [ARM_W-1:0]  ARM_LOAD = ARM_W'(SYNC_STAGES + 1);
    localparam logic [1:0]        RESP_OKAY   = 2'b00;
    localparam logic [1:0]        RESP_SLVERR = 2'b10;

    logic [N_SRC-1:0] sync_q [SYNC_STAGES];
    logic [N_SRC-1:0] prev_q;
    logic [N_SRC-1:0] rise_q;
    logic [ARM_W-1:0] arm_cnt;
    logic [N_SRC-1:0] pending;
    logic [N_SRC-1:0] enable;
    logic [N_SRC-1:0] pend_nxt;
    logic [N_SRC-1:0] active;
    logic [4:0]       id_val;
    logic [31:0]      rd_mux;
    logic [1:0]       wr_sel;
    logic [1:0]       rd_sel;
    logic             wr_fire;
    logic             rd_fire;
    logic             wr_err;
    logic             rd_err;
    logic             unused_bits;

    assign wr_sel  = awaddr[3:2];
    assign rd_sel  = araddr[3:2];
    assign wr_fire = awready & awvalid & wvalid;
    assign rd_fire = arready & arvalid;
    assign active  = pending & enable;
    assign unused_bits = ^{awaddr[1:0], araddr[1:0], wdata[31:N_SRC]};

    // Lines already high when reset releases would look like rising edges as the
    // chain fills; edge detection stays disarmed until prev_q has caught up.
    always_ff @(posedge clk_50_mhz) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            prev_q  <= '0;
            rise_q  <= '0;
            arm_cnt <= ARM_LOAD;
        end else begin
            sync_q[0] <= irq_src;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            prev_q <= sync_q[SYNC_STAGES-1];
            rise_q <= (arm_cnt == '0) ? (sync_q[SYNC_STAGES-1] & ~prev_q) : '0;
            if (arm_cnt != '0) arm_cnt <= arm_cnt - 1'b1;
        end
    end

`ifdef IRQ_CTRL_SWTRIG_EN
    assign wr_err = 1'b0;
    assign rd_err = 1'b0;
`else
    assign wr_err = (wr_sel == 2'd3);
    assign rd_err = (rd_sel == 2'd3);
`endif

    // Clear is applied before set so a captured edge always survives a W1C.
    always_comb begin
        pend_nxt = pending;
        if (wr_fire && wr_sel == 2'd0) pend_nxt = pend_nxt & ~wdata[N_SRC-1:0];
`ifdef IRQ_CTRL_SWTRIG_EN
        if (wr_fire && wr_sel == 2'd3) pend_nxt = pend_nxt | wdata[N_SRC-1:0];
`endif
        pend_nxt = pend_nxt | rise_q;
    end

    always_comb begin
        id_val = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (active[i]) id_val = 5'(i);
        end
    end

    always_comb begin
        rd_mux = '0;
        case (rd_sel)
            2'd0:    rd_mux = {{(32-N_SRC){1'b0}}, pending};
            2'd1:    rd_mux = {{(32-N_SRC){1'b0}}, enable};
            2'd2:    rd_mux = {|active, 26'd0, id_val};
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_50_mhz) begin
        if (rst) begin
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            rresp   <= RESP_OKAY;
            pending <= '0;
            enable  <= '0;
            irq_out <= 1'b0;
        end else begin
            awready <= awvalid & wvalid & ~bvalid & ~awready;
            wready  <= awvalid & wvalid & ~bvalid & ~awready;
            if (wr_fire) begin
                bvalid <= 1'b1;
                bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end else if (bvalid && bready) begin
                bvalid <= 1'b0;
            end

            arready <= arvalid & ~rvalid & ~arready;
            if (rd_fire) begin
                rvalid <= 1'b1;
                rdata  <= rd_mux;
                rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end else if (rvalid && rready) begin
                rvalid <= 1'b0;
            end

            if (wr_fire && wr_sel == 2'd1) enable <= wdata[N_SRC-1:0];
            pending <= pend_nxt;
            irq_out <= |active;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl (N_SRC=8, SYNC_STAGES=2).
module tb_irq_ctrl;

    logic        clk_50_mhz = 1'b0;
    logic        rst;
    logic [7:0]  irq_src;
    logic [3:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic        irq_out;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [31:0] rd;
    logic [1:0]  rs;
    int          n;

    irq_ctrl #(.N_SRC(8), .SYNC_STAGES(2)) dut (
        .clk_50_mhz(clk_50_mhz), .rst(rst), .irq_src(irq_src),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .irq_out(irq_out)
    );

    always #10 clk_50_mhz = ~clk_50_mhz;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic wait_neg(input int cycles);
        for (int k = 0; k < cycles; k++) @(negedge clk_50_mhz);
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, output logic [1:0] resp);
        int t;
        @(negedge clk_50_mhz);
        awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
        t = 0;
        while (!awready && t < 20) begin @(negedge clk_50_mhz); t++; end
        chk("wr_awready", {31'd0, awready & wready}, 32'd1);
        @(posedge clk_50_mhz); #1;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        t = 0;
        @(negedge clk_50_mhz);
        while (!bvalid && t < 20) begin @(negedge clk_50_mhz); t++; end
        chk("wr_bvalid", {31'd0, bvalid}, 32'd1);
        resp = bresp;
        @(posedge clk_50_mhz); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] resp);
        int t;
        @(negedge clk_50_mhz);
        araddr = a; arvalid = 1'b1;
        t = 0;
        while (!arready && t < 20) begin @(negedge clk_50_mhz); t++; end
        chk("rd_arready", {31'd0, arready}, 32'd1);
        @(posedge clk_50_mhz); #1;
        arvalid = 1'b0; rready = 1'b1;
        t = 0;
        @(negedge clk_50_mhz);
        while (!rvalid && t < 20) begin @(negedge clk_50_mhz); t++; end
        chk("rd_rvalid", {31'd0, rvalid}, 32'd1);
        d = rdata; resp = rresp;
        @(posedge clk_50_mhz); #1;
        rready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; irq_src = 8'hFF;
        awaddr = '0; awvalid = 1'b0; wdata = '0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;

        // Reset with all lines held high
        repeat (3) @(posedge clk_50_mhz);
        #1 rst = 1'b0;
        @(negedge clk_50_mhz);
        chk("rst_ctrl", {22'd0, awready, wready, bvalid, arready, rvalid, irq_out, bresp, rresp}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        wait_neg(8);
        axi_read(4'h0, rd, rs);
        chk("rst_pending", rd, 32'h0);
        chk("rst_rresp", {30'd0, rs}, 32'd0);
        irq_src = 8'h00;
        wait_neg(5);

        // Edge capture latency
        axi_write(4'h4, 32'h05, rs);
        chk("en_bresp", {30'd0, rs}, 32'd0);
        @(negedge clk_50_mhz); irq_src[2] = 1'b1;
        @(posedge clk_50_mhz);
        @(negedge clk_50_mhz); irq_src[2] = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk_50_mhz);
            chk($sformatf("lat_irq_t%0d", k), {31'd0, irq_out}, (k >= 4) ? 32'd1 : 32'd0);
        end
        axi_read(4'h8, rd, rs);
        chk("lat_id", rd, 32'h8000_0002);
        axi_read(4'h0, rd, rs);
        chk("lat_pending", rd, 32'h04);
        axi_write(4'h0, 32'h04, rs);
        axi_read(4'h8, rd, rs);
        chk("w1c_id", rd, 32'h0);

        // Priority and masking
        axi_write(4'h4, 32'h48, rs);
        @(negedge clk_50_mhz); irq_src = 8'h4A;
        @(negedge clk_50_mhz); irq_src = 8'h00;
        wait_neg(6);
        axi_read(4'h8, rd, rs);
        chk("prio_id3", rd, 32'h8000_0003);
        chk("prio_irq", {31'd0, irq_out}, 32'd1);
        axi_write(4'h0, 32'h08, rs);
        axi_read(4'h8, rd, rs);
        chk("prio_id6", rd, 32'h8000_0006);
        axi_write(4'h4, 32'h00, rs);
        wait_neg(2);
        chk("mask_irq", {31'd0, irq_out}, 32'd0);
        axi_read(4'h8, rd, rs);
        chk("mask_id", rd, 32'h0);
        axi_read(4'h0, rd, rs);
        chk("mask_pending", rd, 32'h42);
        axi_write(4'h0, 32'h42, rs);
        axi_read(4'h0, rd, rs);
        chk("clr_pending", rd, 32'h0);

        // Set wins over W1C on the same edge
        @(negedge clk_50_mhz); irq_src[0] = 1'b1;
        @(posedge clk_50_mhz);
        @(negedge clk_50_mhz); irq_src[0] = 1'b0;
        @(negedge clk_50_mhz);
        awaddr = 4'h0; wdata = 32'h1; awvalid = 1'b1; wvalid = 1'b1;
        @(negedge clk_50_mhz);
        chk("coll_awready", {31'd0, awready}, 32'd1);
        @(posedge clk_50_mhz); #1;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        @(posedge clk_50_mhz); #1 bready = 1'b0;
        axi_read(4'h0, rd, rs);
        chk("coll_pending", rd, 32'h01);
        axi_write(4'h0, 32'h01, rs);
        axi_read(4'h0, rd, rs);
        chk("coll_cleared", rd, 32'h0);

        // Write handshake: address alone, then held response blocks a second write
        @(negedge clk_50_mhz);
        awaddr = 4'h4; wdata = 32'h3; awvalid = 1'b1; wvalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_50_mhz);
            chk("aw_alone", {31'd0, awready | wready}, 32'd0);
        end
        wvalid = 1'b1;
        n = 0;
        while (!awready && n < 10) begin @(negedge clk_50_mhz); n++; end
        chk("hs_awready", {31'd0, awready}, 32'd1);
        @(posedge clk_50_mhz); #1;
        wdata = 32'h7;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_50_mhz);
            chk("bvalid_hold", {31'd0, bvalid}, 32'd1);
            chk("no_accept", {31'd0, awready}, 32'd0);
        end
        bready = 1'b1;
        @(posedge clk_50_mhz); #1 bready = 1'b0;
        n = 0;
        @(negedge clk_50_mhz);
        while (!awready && n < 10) begin @(negedge clk_50_mhz); n++; end
        chk("hs2_awready", {31'd0, awready}, 32'd1);
        @(posedge clk_50_mhz); #1;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        @(negedge clk_50_mhz);
        chk("hs2_bvalid", {29'd0, bvalid, bresp}, 32'h4);
        @(posedge clk_50_mhz); #1 bready = 1'b0;

        // Read stall keeps rdata stable
        @(negedge clk_50_mhz);
        araddr = 4'h4; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 10) begin @(negedge clk_50_mhz); n++; end
        chk("stall_arready", {31'd0, arready}, 32'd1);
        @(posedge clk_50_mhz); #1 arvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_50_mhz);
            chk("rvalid_hold", {31'd0, rvalid}, 32'd1);
            chk("rdata_stable", rdata, 32'h7);
        end
        rready = 1'b1;
        @(posedge clk_50_mhz); #1 rready = 1'b0;
        @(negedge clk_50_mhz);
        chk("rvalid_clr", {31'd0, rvalid}, 32'd0);

        // Simultaneous read and write of ENABLE: read sees the old value
        @(negedge clk_50_mhz);
        awaddr = 4'h4; wdata = 32'h1; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 4'h4; arvalid = 1'b1;
        @(negedge clk_50_mhz);
        chk("sim_ready", {30'd0, awready, arready}, 32'h3);
        @(posedge clk_50_mhz); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
        @(negedge clk_50_mhz);
        chk("sim_valid", {30'd0, bvalid, rvalid}, 32'h3);
        chk("sim_rdata", rdata, 32'h7);
        @(posedge clk_50_mhz); #1 bready = 1'b0; rready = 1'b0;
        axi_read(4'h4, rd, rs);
        chk("sim_enable", rd, 32'h1);

        // SWTRIG window
        axi_write(4'hC, 32'h10, rs);
`ifdef IRQ_CTRL_SWTRIG_EN
        chk("swtrig_bresp", {30'd0, rs}, 32'h0);
        axi_read(4'h0, rd, rs);
        chk("swtrig_pending", rd, 32'h10);
        axi_read(4'hC, rd, rs);
        chk("swtrig_rd", {rd[29:0], rs}, 32'h0);
`else
        chk("swtrig_bresp", {30'd0, rs}, 32'h2);
        axi_read(4'h0, rd, rs);
        chk("swtrig_pending", rd, 32'h0);
        axi_read(4'hC, rd, rs);
        chk("swtrig_rd", {rd[29:0], rs}, 32'h2);
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
